fp16_accum_seq: RTL
===================

Name: fp16_accum_seq

Overview:
Sequencer that sums an N-element FP16 stream by driving the SFU's two-operand FP16 adder stage and consuming its results. It sits directly upstream of the adder, driving its op_a, op_b and mode inputs, and directly downstream of it, capturing its result. The accumulator is fed back as op_a, so one element is in flight at a time. The final sum is presented on a valid/ready output.

Parameters:
ADD_LAT, 2, adder pipeline depth; add_res is valid ADD_LAT edges after operands are first presented.
CNT_W, 8, width of the element-count input; maximum length is 2^CNT_W-1.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; samples len; ignored unless in IDLE
len  input  CNT_W  number of elements to sum
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid&&in_ready
in_data  input  16  FP16 element
add_op_a  output  16  registered; to adder op_a (accumulator)
add_op_b  output  16  registered; to adder op_b (element)
add_mode  output  1  to adder mode (0 add, 1 subtract)
add_res  input  16  adder result
out_valid  output  1  sum valid; held until out_ready
out_ready  input  1  sum consumed when out_valid&&out_ready
out_data  output  16  FP16 sum
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE. in_ready, out_valid, busy, add_mode=0. add_op_a, add_op_b, out_data, acc=16'h0000. Remaining count=0.
- IDLE: on start with len==0, go to DONE with acc=16'h0000. On start with len>=1, remaining<=len-1 and go to LOAD.
- LOAD: in_ready=1. On handshake, acc<=in_data. If remaining==0, go to DONE; else go to ISSUE. No adder operation is issued for the first element.
- ISSUE: in_ready=1. On handshake, add_op_a<=acc, add_op_b<=in_data, remaining<=remaining-1, wait counter<=0, go to WAIT.
- WAIT: in_ready=0. The operands are held stable. The state lasts exactly ADD_LAT+1 cycles. On the last cycle, acc<=add_res, then go to DONE if remaining==0, else to ISSUE.
- DONE: out_valid=1 and out_data=acc. Both are held stable until out_ready; on that handshake, go to IDLE. The adder's own done output is not used; timing comes from the internal counter only.
- in_ready is combinational from state (high only in LOAD and ISSUE). It does not depend on in_valid.
- Latency with in_valid always high and N>=2: out_valid rises 2+(N-1)*(ADD_LAT+2) cycles after the start cycle (14 cycles for N=4, ADD_LAT=2).
- Input gaps: LOAD and ISSUE wait indefinitely with no timeout. Output backpressure: DONE holds indefinitely.
- start while busy is ignored, including a start in the same cycle as the DONE handshake; the block returns to IDLE first.
- rst mid-operation: next cycle is IDLE with all reset values. Any adder result in flight is discarded.
- Arithmetic: no FP logic inside the block; rounding and special values are the adder's job. NaN/Inf in add_res pass into acc unchanged.

Optional Feature:
FP16_ACC_SUB_EN:
- Defined: adds an input port sub (1 bit), sampled into a register on an accepted start. add_mode drives that register, so elements 2..N are subtracted from the first. sub resets to 0.
- Undefined: no sub port; add_mode is tied to 0.

Test Plan:
- len=4, elements 0x3C00,0x4000,0x4200,0x4400, in_valid always high, out_ready=1 -> out_data=0x4900 (10.0); out_valid in cycle start+14; busy low the cycle after the handshake.
- len=0 -> DONE the cycle after start with out_data=0x0000; in_ready never high.
- len=1, element 0x4500 -> out_data=0x4500; add_op_a/add_op_b remain 0x0000.
- len=3 with a 5-cycle in_valid gap before element 2, and out_ready low for 4 cycles -> correct sum; out_data stable while out_valid high; start pulses during busy ignored.
- rst asserted in WAIT of the second element -> next cycle: IDLE, out_valid=0, acc=0. A new len=2 run (0x3C00,0x3C00) -> 0x4000.
- FP16_ACC_SUB_EN defined, sub=1, len=3, elements 0x4900,0x3C00,0x4000 -> add_mode=1, out_data=0x4700 (7.0).

Source files
------------

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: sums an N-element FP16 stream by sequencing an external
// two-operand FP16 adder with ADD_LAT pipeline stages. The accumulator is fed
// back as op_a, so exactly one addition is in flight at a time, and the final
// sum is held on a valid/ready output until it is consumed.
// Optional feature macro: FP16_ACC_SUB_EN (adds a 'sub' port; when set on an
// accepted start, elements 2..N are subtracted from the first).
module fp16_accum_seq #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic [15:0]      add_op_a,
  output logic [15:0]      add_op_b,
  output logic             add_mode,
  input  logic [15:0]      add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
`ifdef FP16_ACC_SUB_EN
  ,
  input  logic             sub
`endif
);

  // Wait counter runs 0..ADD_LAT; keep it at least one bit wide.
  localparam int unsigned WAIT_W = (ADD_LAT == 0) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADD_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_remaining;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [15:0]       r_acc;
  logic [15:0]       r_op_a;
  logic [15:0]       r_op_b;
  logic [15:0]       r_out_data;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              r_busy;

  wire w_in_hs  = in_valid && r_in_ready;
  wire w_out_hs = r_out_valid && out_ready;

  // Sequencer: state, counters, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_acc       <= 16'h0000;
      r_op_a      <= 16'h0000;
      r_op_b      <= 16'h0000;
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len == '0) begin
              r_acc       <= 16'h0000;
              r_out_data  <= 16'h0000;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_remaining <= len - CNT_W'(1);
              r_in_ready  <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
        end

        // First element goes straight into the accumulator, no adder op.
        S_LOAD: begin
          if (w_in_hs) begin
            r_acc <= in_data;
            if (r_remaining == '0) begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (w_in_hs) begin
            r_op_a      <= r_acc;
            r_op_b      <= in_data;
            r_remaining <= r_remaining - CNT_W'(1);
            r_wait_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        // Operands held for ADD_LAT+1 cycles; result sampled on the last one.
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_acc <= add_res;
            if (r_remaining == '0) begin
              r_out_data  <= add_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        // Sum held until consumed; a start in this cycle is ignored.
        S_DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FP16_ACC_SUB_EN
  logic r_sub;

  // Operation mode latched on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (start && (r_state == S_IDLE)) begin
      r_sub <= sub;
    end
  end

  assign add_mode = r_sub;
`else
  assign add_mode = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign add_op_a  = r_op_a;
  assign add_op_b  = r_op_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
